// File: rtl/gpr_scoreboard.sv
// GPR write scoreboard: per-register pending-write counters between issue and writeback.
// Stalls issue on RAW hazards and on per-register write-counter saturation.
module gpr_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [IDX_W-1:0]    issue_rd_i,
    input  logic                issue_rd_we_i,
    input  logic [IDX_W-1:0]    issue_rj_i,
    input  logic                issue_rj_re_i,
    input  logic [IDX_W-1:0]    issue_rk_i,
    input  logic                issue_rk_re_i,
    input  logic                wb_valid_i,
    input  logic [IDX_W-1:0]    wb_rd_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] busy_vec_o,
    output logic                err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;

    logic                rj_busy_c, rk_busy_c, sat_c, fire_c;
    logic [NUM_REGS-1:0] inc_c, dec_c;

    // Hazard detection; a source whose last pending write retires this cycle is bypassed
    always_comb begin
        rj_busy_c = issue_rj_re_i && (issue_rj_i != '0) && (cnt_q[issue_rj_i] != '0)
                    && !(wb_valid_i && (wb_rd_i == issue_rj_i) && (cnt_q[issue_rj_i] == CNT_ONE));
        rk_busy_c = issue_rk_re_i && (issue_rk_i != '0) && (cnt_q[issue_rk_i] != '0)
                    && !(wb_valid_i && (wb_rd_i == issue_rk_i) && (cnt_q[issue_rk_i] == CNT_ONE));
        sat_c     = issue_rd_we_i && (issue_rd_i != '0) && (cnt_q[issue_rd_i] == CNT_MAX)
                    && !(wb_valid_i && (wb_rd_i == issue_rd_i));
        issue_ready_o = !flush_i && !rj_busy_c && !rk_busy_c && !sat_c;
        fire_c        = issue_valid_i && issue_ready_o;
    end

    // Counter next state: flush, then inc/dec cancel, then single inc or dec
    always_comb begin
        inc_c  = '0;
        dec_c  = '0;
        busy_d = '0;
        err_d  = err_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            inc_c[r] = fire_c && issue_rd_we_i && (issue_rd_i == IDX_W'(r));
            dec_c[r] = wb_valid_i && (wb_rd_i == IDX_W'(r)) && (cnt_q[r] != '0);
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (inc_c[r] && !dec_c[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_c[r] && !inc_c[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
        if (!flush_i && wb_valid_i && (wb_rd_i != '0) && (cnt_q[wb_rd_i] == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed self-checking bench for gpr_scoreboard.
module tb_gpr_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid, issue_ready, issue_rd_we, issue_rj_re, issue_rk_re;
    logic [4:0]  issue_rd, issue_rj, issue_rk, wb_rd;
    logic        wb_valid, flush, err;
    logic [31:0] busy_vec;
    int          checks = 0;
    int          failures = 0;

    gpr_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_rd_i    (issue_rd),
        .issue_rd_we_i (issue_rd_we),
        .issue_rj_i    (issue_rj),
        .issue_rj_re_i (issue_rj_re),
        .issue_rk_i    (issue_rk),
        .issue_rk_re_i (issue_rk_re),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .flush_i       (flush),
        .busy_vec_o    (busy_vec),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rd_we = 0;
        issue_rj = 0; issue_rj_re = 0; issue_rk = 0; issue_rk_re = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic iss(input logic [4:0] rd, input logic we, input logic [4:0] rj,
                       input logic rjre, input logic [4:0] rk, input logic rkre);
        issue_valid = 1; issue_rd = rd; issue_rd_we = we;
        issue_rj = rj; issue_rj_re = rjre; issue_rk = rk; issue_rk_re = rkre;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1; wb_rd = rd;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        cyc(); cyc();
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst = 0;
        cyc();
        chk("post_rst_ready", {31'b0, issue_ready}, 32'h1);
        chk("post_rst_busy", busy_vec, 32'h0);

        // Basic issue to r5
        iss(5, 1, 0, 0, 0, 0); #1;
        chk("basic_ready", {31'b0, issue_ready}, 32'h1);
        cyc(); idle();
        chk("basic_busy5", busy_vec, 32'h0000_0020);
        wb(5); cyc(); idle();
        chk("basic_clear5", busy_vec, 32'h0);
        chk("basic_err", {31'b0, err}, 32'h0);

        // RAW stall and same-cycle writeback bypass on r7
        iss(7, 1, 0, 0, 0, 0); cyc(); idle();
        chk("raw_busy7", busy_vec, 32'h0000_0080);
        iss(0, 0, 7, 1, 0, 0); #1;
        chk("raw_rj_stall", {31'b0, issue_ready}, 32'h0);
        iss(0, 0, 0, 0, 7, 1); #1;
        chk("raw_rk_stall", {31'b0, issue_ready}, 32'h0);
        iss(0, 0, 7, 1, 0, 0); wb(7); #1;
        chk("raw_bypass_ready", {31'b0, issue_ready}, 32'h1);
        cyc(); idle();
        chk("raw_bypass_busy", busy_vec, 32'h0);

        // Bypass applies only to the last pending write
        iss(8, 1, 0, 0, 0, 0); cyc();
        iss(8, 1, 0, 0, 0, 0); cyc(); idle();
        iss(0, 0, 8, 1, 0, 0); wb(8); #1;
        chk("raw_cnt2_no_bypass", {31'b0, issue_ready}, 32'h0);
        cyc(); idle();
        chk("raw_cnt2_after_wb", busy_vec, 32'h0000_0100);
        wb(8); cyc(); idle();
        chk("raw_cnt2_clear", busy_vec, 32'h0);

        // WAW saturation on r3
        iss(3, 1, 0, 0, 0, 0); cyc(); cyc(); cyc(); idle();
        chk("waw_busy3", busy_vec, 32'h0000_0008);
        iss(3, 1, 0, 0, 0, 0); #1;
        chk("waw_sat_stall", {31'b0, issue_ready}, 32'h0);
        wb(3); #1;
        chk("waw_sat_wb_ready", {31'b0, issue_ready}, 32'h1);
        cyc(); idle();
        chk("waw_hold_busy", busy_vec, 32'h0000_0008);
        wb(3); cyc(); cyc(); idle();
        chk("waw_still3_after2wb", busy_vec, 32'h0000_0008);
        wb(3); cyc(); idle();
        chk("waw_clear3", busy_vec, 32'h0);
        chk("waw_err", {31'b0, err}, 32'h0);

        // r0 is never tracked
        iss(0, 1, 0, 1, 0, 1); wb(0); #1;
        chk("r0_ready", {31'b0, issue_ready}, 32'h1);
        cyc(); idle();
        chk("r0_busy", busy_vec, 32'h0);
        chk("r0_err", {31'b0, err}, 32'h0);

        // Flush discards pending writes and blocks the same-cycle issue
        iss(1, 1, 0, 0, 0, 0); cyc();
        iss(2, 1, 0, 0, 0, 0); cyc();
        iss(31, 1, 0, 0, 0, 0); cyc(); idle();
        chk("flush_setup", busy_vec, 32'h8000_0006);
        iss(4, 1, 0, 0, 0, 0); wb(9); flush = 1; #1;
        chk("flush_ready", {31'b0, issue_ready}, 32'h0);
        cyc(); idle();
        chk("flush_busy", busy_vec, 32'h0);
        chk("flush_no_err", {31'b0, err}, 32'h0);
        cyc();
        chk("flush_no_fire", busy_vec, 32'h0);

        // Sticky error, then asynchronous reset between edges
        wb(9); cyc(); idle();
        chk("err_set", {31'b0, err}, 32'h1);
        chk("err_busy", busy_vec, 32'h0);
        iss(6, 1, 0, 0, 0, 0); cyc(); idle();
        chk("err_sticky", {31'b0, err}, 32'h1);
        chk("err_busy6", busy_vec, 32'h0000_0040);
        #2 rst = 1; #1;
        chk("async_err", {31'b0, err}, 32'h0);
        chk("async_busy", busy_vec, 32'h0);
        cyc(); rst = 0; cyc();
        chk("async_ready", {31'b0, issue_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
